// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor encodings, cabin FSM states and a
// saturating one-floor step helper.
package elevator_pkg;

  localparam logic [1:0] ST_FLOOR = 2'b00;
  localparam logic [1:0] ND_FLOOR = 2'b01;
  localparam logic [1:0] RD_FLOOR = 2'b10;
  localparam logic [1:0] NO_FLOOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    DOOR_OPEN
  } state_e;

  // One floor up or down, clamped to ST_FLOOR..RD_FLOOR.
  function automatic logic [1:0] step_floor(input logic [1:0] cur, input logic up);
    logic [1:0] nxt;
    if (up) begin
      nxt = (cur >= RD_FLOOR) ? RD_FLOOR : cur + 2'd1;
    end else begin
      nxt = (cur == ST_FLOOR) ? ST_FLOOR : cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/floor_controller_if.sv
// Request/status bundle between the call-priority stage (master) and the
// cabin floor controller (slave).
//   req_floor/req_valid/req_ready : target floor handshake
//   floor, is_mooving, dir_up     : cabin position and motion status
//   door_open, served/served_floor: door state and arrival pulse
//   door_hold                     : only with FLOOR_CONTROLLER_DOOR_HOLD_EN
interface floor_controller_if;

  logic [1:0] req_floor;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] floor;
  logic       is_mooving;
  logic       dir_up;
  logic       door_open;
  logic       served;
  logic [1:0] served_floor;
`ifdef FLOOR_CONTROLLER_DOOR_HOLD_EN
  logic       door_hold;
`endif

  modport master (
    output req_floor,
    output req_valid,
    input  req_ready,
    input  floor,
    input  is_mooving,
    input  dir_up,
    input  door_open,
    input  served,
    input  served_floor
`ifdef FLOOR_CONTROLLER_DOOR_HOLD_EN
    ,
    output door_hold
`endif
  );

  modport slave (
    input  req_floor,
    input  req_valid,
    output req_ready,
    output floor,
    output is_mooving,
    output dir_up,
    output door_open,
    output served,
    output served_floor
`ifdef FLOOR_CONTROLLER_DOOR_HOLD_EN
    ,
    input  door_hold
`endif
  );

endinterface

// File: rtl/move_timer.sv
// 8-bit loadable down-counter with zero flag; used for travel and door dwell.
//   clk, rst  : clock, synchronous active-high reset (clears count)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, holding at zero
//   zero      : count is zero
module move_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != 8'd0)) begin
      count_q <= count_q - 8'd1;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/floor_controller.sv
// Cabin movement controller: accepts one target floor in IDLE, moves one floor
// per TRAVEL_CYCLES, then holds the door open for DOOR_CYCLES with a one-cycle
// served pulse on arrival.
//   clk, rst : clock, synchronous active-high reset
//   bus      : floor_controller_if.slave (request handshake + status outputs)
// Optional macro FLOOR_CONTROLLER_DOOR_HOLD_EN adds bus.door_hold, which keeps
// reloading the door timer while high.
module floor_controller
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 16
) (
  input logic               clk,
  input logic               rst,
  floor_controller_if.slave bus
);

  localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] floor_q, floor_d;
  logic [1:0] target_q, target_d;
  logic       dir_up_q, dir_up_d;
  logic       served_q, served_d;
  logic [1:0] served_floor_q, served_floor_d;

  logic       travel_load, travel_dec, travel_zero;
  logic       door_load, door_dec, door_zero;
  logic       hold;
  logic [1:0] next_floor;

`ifdef FLOOR_CONTROLLER_DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  assign next_floor = step_floor(floor_q, dir_up_q);

  move_timer u_travel_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (travel_load),
    .load_val (TRAVEL_LOAD),
    .dec      (travel_dec),
    .zero     (travel_zero)
  );

  move_timer u_door_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (door_load),
    .load_val (DOOR_LOAD),
    .dec      (door_dec),
    .zero     (door_zero)
  );

  always_comb begin
    state_d        = state_q;
    floor_d        = floor_q;
    target_d       = target_q;
    dir_up_d       = dir_up_q;
    served_d       = 1'b0;
    served_floor_d = served_floor_q;
    travel_load    = 1'b0;
    travel_dec     = 1'b0;
    door_load      = 1'b0;
    door_dec       = 1'b0;

    case (state_q)
      IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone is a transfer.
        if (bus.req_valid && (bus.req_floor != NO_FLOOR)) begin
          if (bus.req_floor == floor_q) begin
            state_d        = DOOR_OPEN;
            served_d       = 1'b1;
            served_floor_d = bus.req_floor;
            door_load      = 1'b1;
          end else begin
            state_d     = MOVING;
            target_d    = bus.req_floor;
            dir_up_d    = (bus.req_floor > floor_q);
            travel_load = 1'b1;
          end
        end
      end

      MOVING: begin
        if (travel_zero) begin
          floor_d = next_floor;
          if (next_floor == target_q) begin
            state_d        = DOOR_OPEN;
            served_d       = 1'b1;
            served_floor_d = target_q;
            door_load      = 1'b1;
          end else begin
            travel_load = 1'b1;
          end
        end else begin
          travel_dec = 1'b1;
        end
      end

      DOOR_OPEN: begin
        if (hold) begin
          door_load = 1'b1;
        end else if (door_zero) begin
          state_d = IDLE;
        end else begin
          door_dec = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      floor_q        <= ST_FLOOR;
      target_q       <= ST_FLOOR;
      dir_up_q       <= 1'b1;
      served_q       <= 1'b0;
      served_floor_q <= ST_FLOOR;
    end else begin
      state_q        <= state_d;
      floor_q        <= floor_d;
      target_q       <= target_d;
      dir_up_q       <= dir_up_d;
      served_q       <= served_d;
      served_floor_q <= served_floor_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.is_mooving   = (state_q == MOVING);
  assign bus.door_open    = (state_q == DOOR_OPEN);
  assign bus.floor        = floor_q;
  assign bus.dir_up       = dir_up_q;
  assign bus.served       = served_q;
  assign bus.served_floor = served_floor_q;

endmodule

// File: tb/tb_floor_controller.sv
// Scoreboard bench for floor_controller with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
// Accepted requests push expected floor steps and served events (with cycle
// stamps); a negedge monitor pops and compares them as the DUT produces them.
module tb_floor_controller;

  localparam int TRAV = 4;
  localparam int DOOR = 3;

  typedef struct {
    int         cyc;
    logic [1:0] fl;
    logic       up;
  } step_t;

  typedef struct {
    int         cyc;
    logic [1:0] fl;
    int         dwell;
  } serve_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  int   dwell_exp = DOOR;
  logic [1:0] mf = 2'b00;

  step_t  step_q[$];
  serve_t serve_q[$];

  floor_controller_if bus ();

  floor_controller #(
    .TRAVEL_CYCLES (TRAV),
    .DOOR_CYCLES   (DOOR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: compares DOUT events against scoreboard entries.
  logic [1:0] prev_floor = 2'b00;
  bit         prev_served = 1'b0;
  int         run = 0;
  int         cur_dwell = DOOR;

  always @(negedge clk) begin : monitor
    step_t  st;
    serve_t sv;
    if (!mon_en) begin
      prev_floor  = bus.floor;
      prev_served = 1'b0;
      run         = 0;
    end else begin
      if (bus.floor != prev_floor) begin
        if (step_q.size() == 0) begin
          check("floor_unexpected", step_q.size(), 1);
        end else begin
          st = step_q.pop_front();
          check("floor_val", bus.floor, st.fl);
          check("floor_cyc", cyc, st.cyc);
          check("dir_up", bus.dir_up, st.up);
        end
        prev_floor = bus.floor;
      end
      if (bus.served) begin
        check("served_width", prev_served, 0);
        if (serve_q.size() == 0) begin
          check("served_unexpected", serve_q.size(), 1);
        end else begin
          sv = serve_q.pop_front();
          check("served_floor", bus.served_floor, sv.fl);
          check("served_cyc", cyc, sv.cyc);
          check("door_at_served", bus.door_open, 1);
          check("moving_at_served", bus.is_mooving, 0);
          cur_dwell = sv.dwell;
        end
      end
      prev_served = bus.served;
      if (bus.door_open) begin
        run++;
      end else if (run > 0) begin
        check("door_dwell", run, cur_dwell);
        check("ready_after_door", bus.req_ready, 1);
        run = 0;
      end
    end
  end

  task automatic push_exp(input logic [1:0] f, input int n);
    serve_t sv;
    step_t  st;
    int     k;
    logic   up;
    if (f == 2'b11) return;
    k  = 0;
    up = (f > mf);
    while (mf != f) begin
      mf = up ? mf + 2'd1 : mf - 2'd1;
      k++;
      st.cyc = n + TRAV * k;
      st.fl  = mf;
      st.up  = up;
      step_q.push_back(st);
    end
    sv.cyc   = n + TRAV * k;
    sv.fl    = f;
    sv.dwell = dwell_exp;
    serve_q.push_back(sv);
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) break;
    end
    if (i == 200) check("ready_timeout", bus.req_ready, 1);
  endtask

  // Drives a request at a negedge in IDLE; n returns the accepting edge.
  task automatic request(input logic [1:0] f, output int n);
    wait_ready();
    bus.req_floor = f;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.req_valid = 1'b0;
    push_exp(f, n);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    bus.req_floor = 2'b00;
    bus.req_valid = 1'b0;
`ifdef FLOOR_CONTROLLER_DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_floor", bus.floor, 0);
    check("rst_moving", bus.is_mooving, 0);
    check("rst_dir_up", bus.dir_up, 1);
    check("rst_door", bus.door_open, 0);
    check("rst_served", bus.served, 0);
    check("rst_served_floor", bus.served_floor, 0);
    check("rst_ready", bus.req_ready, 1);
    #1;
    mon_en = 1'b1;

    // 0 -> 2, 2 -> 0, 0 -> 1, then same-floor 1 at 1.
    request(2'b10, n);
    @(negedge clk);
    check("moving_after_accept", bus.is_mooving, 1);
    check("ready_low_moving", bus.req_ready, 0);
    request(2'b00, n);
    request(2'b01, n);
    request(2'b01, n);
    @(negedge clk);
    check("same_floor_no_move", bus.is_mooving, 0);

    // Invalid target is dropped; monitor flags any stray step or served.
    request(2'b11, n);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("inv_ready", bus.req_ready, 1);
      check("inv_moving", bus.is_mooving, 0);
      check("inv_floor", bus.floor, 1);
    end

    // Valid held with churning floor while busy; only the first IDLE value counts.
    wait_ready();
    bus.req_floor = 2'b10;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    push_exp(2'b10, n);
    begin : churn
      int i;
      for (i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.req_ready) break;
        bus.req_floor = 2'($urandom_range(0, 3));
      end
      if (i == 200) check("churn_timeout", bus.req_ready, 1);
    end
    bus.req_floor = 2'b00;
    @(posedge clk);
    #1;
    n = cyc;
    bus.req_valid = 1'b0;
    push_exp(2'b00, n);

    // Reset mid-move at cycle 6 of a 0 -> 2 trip.
    request(2'b10, n);
    repeat (6) @(posedge clk);
    #1;
    check("mid_move_floor", bus.floor, 1);
    mon_en = 1'b0;
    rst = 1'b1;
    step_q.delete();
    serve_q.delete();
    mf = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_floor", bus.floor, 0);
    check("mid_rst_moving", bus.is_mooving, 0);
    check("mid_rst_door", bus.door_open, 0);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_dir_up", bus.dir_up, 1);
    check("mid_rst_served", bus.served, 0);
    @(negedge clk);
    #1;
    mon_en = 1'b1;

    request(2'b01, n);

`ifdef FLOOR_CONTROLLER_DOOR_HOLD_EN
    // Same-floor request with door_hold high for 5 cycles: door open 8 cycles.
    dwell_exp = 8;
    wait_ready();
    bus.req_floor = 2'b01;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    bus.req_valid = 1'b0;
    bus.door_hold = 1'b1;
    push_exp(2'b01, n);
    repeat (5) @(posedge clk);
    #1;
    bus.door_hold = 1'b0;
    dwell_exp = DOOR;
`endif

    wait_ready();
    repeat (3) @(negedge clk);
    check("steps_drained", step_q.size(), 0);
    check("serves_drained", serve_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/floor_controller.md
# floor_controller

Cabin movement controller sitting directly downstream of the call-priority stage. It accepts one target floor at a time, moves the cabin one floor per travel period, and opens the door for a fixed dwell on arrival. It drives the registered current floor and the `is_mooving` status that the priority stage consumes, and it emits a one-cycle `served` pulse so upstream logic can clear the matching call LED.

## Interface
Parameters:
- `TRAVEL_CYCLES`, default 8: clock cycles per one-floor move; legal range 1..255.
- `DOOR_CYCLES`, default 16: clock cycles the door stays open; legal range 1..255.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_floor`  in  2  target floor: 2'b00 first, 2'b01 second, 2'b10 third; 2'b11 is invalid.
- `req_valid`  in  1  a target is offered on `req_floor`.
- `req_ready`  out  1  high only in IDLE; a request transfers when `req_valid && req_ready`.
- `floor`  out  2  registered current cabin floor.
- `is_mooving`  out  1  high while in MOVING.
- `dir_up`  out  1  direction of the current or last move; 1 means up.
- `door_open`  out  1  high while in DOOR_OPEN.
- `served`  out  1  one-cycle pulse on arrival at the target.
- `served_floor`  out  2  floor being served; valid while `served` is high.

## Operation
- Reset values: `floor`=2'b00, `is_mooving`=0, `dir_up`=1, `door_open`=0, `served`=0, `served_floor`=2'b00. The FSM resets to IDLE and both timers clear.
- IDLE:
  - Valid transfer with `req_floor`==2'b11: the request is dropped and the FSM stays in IDLE.
  - Valid transfer with `req_floor`==`floor`: go to DOOR_OPEN and pulse `served`. No movement occurs and `dir_up` is unchanged.
  - Valid transfer with any other floor: latch the target, set `dir_up`=(target>`floor`), load the travel timer with TRAVEL_CYCLES-1, and go to MOVING.
- MOVING:
  - The timer decrements once per cycle.
  - When the timer is 0: `floor` steps by ±1 according to `dir_up`.
  - If the new floor equals the target: go to DOOR_OPEN, pulse `served`, set `served_floor` to the target, and load the door timer with DOOR_CYCLES-1.
  - Otherwise: reload the travel timer and stay in MOVING.
- DOOR_OPEN: the door timer decrements once per cycle. When it is 0, go to IDLE.
- Request inputs are ignored outside IDLE. There is no queueing; buffering belongs upstream.
- Arithmetic: `floor` saturates in the range 0..2. The latched target is never 2'b11, so a step never wraps.
- `rst` asserted in any state, including mid-move, returns all outputs to their reset values on the next edge. The cabin position is not retained.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs except `req_ready`, which decodes the state register.
- Let edge N be the edge that accepts a request:
  - `is_mooving` rises after edge N.
  - `floor` changes after edges N+TRAVEL_CYCLES, N+2·TRAVEL_CYCLES, and so on.
  - On the final step edge, `is_mooving` falls and `door_open` rises together with the `served` pulse.
- A same-floor request: `door_open` and `served` assert after edge N.
- `door_open` is high for exactly DOOR_CYCLES cycles. `req_ready` returns high on the cycle after the door closes.
- Back-to-back: a request held valid through DOOR_OPEN is accepted on the first IDLE cycle.

## Configuration
- `FLOOR_CONTROLLER_DOOR_HOLD_EN`:
  - When defined: adds input port `door_hold` (1 bit). While `door_hold` is high in DOOR_OPEN, the door timer reloads DOOR_CYCLES-1 every cycle, so the door closes DOOR_CYCLES cycles after `door_hold` falls.
  - When undefined: the port is absent and the dwell is fixed.

## Structure
- Shared package `elevator_pkg`:
  - floor constants `ST_FLOOR`=2'b00, `ND_FLOOR`=2'b01, `RD_FLOOR`=2'b10, `NO_FLOOR`=2'b11;
  - FSM state typedef {IDLE, MOVING, DOOR_OPEN}.
- One sub-module, `move_timer`: an 8-bit loadable down-counter with a `zero` flag. It is instantiated twice, once for travel and once for door dwell.

## Test plan
All scenarios use TRAVEL_CYCLES=4 and DOOR_CYCLES=3.
- Reset then request floor 2'b10 at edge 0:
  - `floor` becomes 01 after edge 4 and 10 after edge 8.
  - `served`=1 with `served_floor`=10 for one cycle after edge 8.
  - `door_open` stays high for 3 cycles, then `req_ready`=1.
- From floor 10, request 00: `dir_up`=0, `floor` goes 01 then 00 at 4-cycle spacing, and `served_floor`=00.
- Request equal to the current floor (01 at 01): no movement, `served` pulses on the next edge, and `door_open` stays high for 3 cycles.
- Request 2'b11 in IDLE: dropped; all outputs unchanged and the FSM stays in IDLE.
- `req_valid` held high with a changing `req_floor` during MOVING: ignored. After the door closes, the value present at the first IDLE cycle is accepted.
- `rst` pulsed at mid-move cycle 6: the edge after `rst` yields `floor`=00, `is_mooving`=0, `door_open`=0 and state IDLE. With `FLOOR_CONTROLLER_DOOR_HOLD_EN`, holding `door_hold` for 5 cycles extends `door_open` to 8 cycles.
